bit_4_restoring_divider: RTL and testbench
==========================================

BIT_4_RESTORING_DIVIDER -- requirements
Module: bit_4_restoring_divider

Interface
REQ-001 The block SHALL use one clock and one reset: the clock is synchronous and the reset is synchronous and active-low.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n SHALL be input, 1 bit, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 Port start SHALL be input, 1 bit, request to begin a division; it is accepted only in IDLE.
REQ-005 Port dividend SHALL be input, 4 bits, unsigned numerator; it is sampled when start is accepted.
REQ-006 Port divisor SHALL be input, 4 bits, unsigned denominator; it is sampled when start is accepted.
REQ-007 Port quotient SHALL be output, 4 bits, registered unsigned quotient.
REQ-008 Port remainder SHALL be output, 4 bits, registered unsigned remainder.
REQ-009 Port busy SHALL be output, 1 bit, high while a division is in progress (RUN or DONE).
REQ-010 Port done SHALL be output, 1 bit, a one-cycle pulse marking that the results are valid.
REQ-011 Port div_by_zero SHALL be output, 1 bit, flag set when the accepted divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL, at the edge:
- capture Q=dividend, M=divisor and A=5'b0;
- set the iteration counter to 4;
- go to RUN when divisor!=0.
REQ-014 IDLE with start=1 and divisor=0 SHALL, at the edge:
- go directly to DONE;
- load quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-015 Each RUN cycle SHALL perform one restoring step, in this order:
- shift {A,Q} left by one;
- form trial = A - {1'b0,M} at 5-bit width;
- if trial[4]=1 (negative): restore A and set Q[0]=0;
- else: set A=trial and Q[0]=1;
- decrement the counter.
REQ-016 After the 4th RUN step, the state SHALL go to DONE, with quotient=Q and remainder=A[3:0] loaded at that same edge, and div_by_zero=0.
REQ-017 done SHALL be 1 only while in DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-018 Latency from the start-accept edge to done high SHALL be 5 cycles for a nonzero divisor and 1 cycle for divisor=0.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; operands SHALL NOT be resampled in that case.
REQ-021 A start present in the DONE cycle SHALL be ignored; the earliest acceptance SHALL be the following IDLE cycle.
REQ-022 quotient, remainder and div_by_zero SHALL hold their last values until the next completion or reset, and SHALL NOT change during RUN.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for all 240 nonzero-divisor pairs.
REQ-024 Internal arithmetic SHALL be 5 bits wide so that the borrow is visible; there SHALL be no overflow for any 4-bit operands.

Reset
REQ-025 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0 and A=0.
REQ-026 A reset applied mid-RUN or in DONE SHALL abort the operation with no done pulse; the first accept after rst_n returns to 1 SHALL behave as if no operation had ever been started.
REQ-027 start SHALL be ignored on any edge where rst_n=0.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- dividend=13, divisor=4, start one cycle -> done 5 cycles later; quotient=3, remainder=1, div_by_zero=0, busy high for 5 cycles.
- dividend=15, divisor=1 -> quotient=15, remainder=0; then dividend=3, divisor=9 -> quotient=0, remainder=3.
- dividend=7, divisor=0 -> done 1 cycle after accept; quotient=4'hF, remainder=7, div_by_zero=1; the next valid divide clears div_by_zero.
- 13/4 accepted, then start=1 with 15/1 held throughout RUN and DONE -> first result 3 r1; the second is accepted only in the following IDLE cycle and gives 15 r0.
- rst_n=0 for one cycle on the 2nd RUN cycle -> no done pulse; all outputs 0; a following 9/2 gives 4 r1.
- Exhaustive sweep over all 256 pairs -> REQ-023 holds for every nonzero divisor and REQ-014 holds for every zero divisor.

Source files
------------

// File: rtl/bit_4_restoring_divider_if.sv
// Operand/result bundle for the 4-bit restoring divider.
// The master drives the operands and start; the slave (the divider) returns the results.
interface bit_4_restoring_divider_if;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/bit_4_restoring_divider.sv
// 4-bit unsigned restoring divider: one quotient bit per RUN cycle, then a one-cycle DONE pulse.
// A zero divisor skips RUN and reports quotient=F, remainder=dividend and div_by_zero.
module bit_4_restoring_divider (
  input  logic                      clk,
  input  logic                      rst_n,
  bit_4_restoring_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     r_state;
  logic [4:0] r_a;
  logic [3:0] r_q;
  logic [3:0] r_m;
  logic [2:0] r_cnt;
  logic [3:0] r_quotient;
  logic [3:0] r_remainder;
  logic       r_busy;
  logic       r_done;
  logic       r_dbz;

  logic [8:0] w_aq_shift;
  logic [4:0] w_trial;
  logic [4:0] w_a_next;
  logic [3:0] w_q_next;

  // The 5-bit trial keeps the borrow in bit 4, which decides restore vs. accept.
  assign w_aq_shift = {r_a, r_q} << 1;
  assign w_trial    = w_aq_shift[8:4] - {1'b0, r_m};
  assign w_a_next   = w_trial[4] ? w_aq_shift[8:4] : w_trial;
  assign w_q_next   = {w_aq_shift[3:1], ~w_trial[4]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= 5'd0;
      r_q         <= 4'd0;
      r_m         <= 4'd0;
      r_cnt       <= 3'd0;
      r_quotient  <= 4'd0;
      r_remainder <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_q    <= bus.dividend;
            r_m    <= bus.divisor;
            r_a    <= 5'd0;
            r_cnt  <= 3'd4;
            r_busy <= 1'b1;
            if (bus.divisor == 4'd0) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_quotient  <= 4'hF;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - 3'd1;
          // Results are published on the same edge as the final step.
          if (r_cnt == 3'd1) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_a_next[3:0];
            r_dbz       <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_bit_4_restoring_divider.sv
// Directed bench for the 4-bit restoring divider: named scenarios plus a full 256-pair sweep.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after a rising edge.
module tb_bit_4_restoring_divider;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bit_4_restoring_divider_if bus_if ();

  bit_4_restoring_divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle start and follow it until done, checking latency, busy span,
  // result stability during RUN, the results themselves and the return to idle.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int exp_lat, input logic [3:0] exp_q, input logic [3:0] exp_r,
                        input logic exp_z);
    int         cycles;
    int         busy_cycles;
    logic [3:0] prev_q;
    logic [3:0] prev_r;
    @(negedge clk);
    prev_q = bus_if.quotient;
    prev_r = bus_if.remainder;
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    cycles      = 0;
    busy_cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (bus_if.busy) busy_cycles++;
      if (bus_if.done) break;
      check({tag, "_hold_q"}, bus_if.quotient, prev_q);
      check({tag, "_hold_r"}, bus_if.remainder, prev_r);
      if (cycles > 20) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_busy_cycles"}, busy_cycles, exp_lat);
    check({tag, "_quotient"}, bus_if.quotient, exp_q);
    check({tag, "_remainder"}, bus_if.remainder, exp_r);
    check({tag, "_dbz"}, bus_if.div_by_zero, exp_z);
    @(negedge clk);
    check({tag, "_done_low"}, bus_if.done, 1'b0);
    check({tag, "_busy_low"}, bus_if.busy, 1'b0);
    $display("[TB] %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b,
             bus_if.quotient, bus_if.remainder, bus_if.div_by_zero, cycles);
  endtask

  initial begin
    int         cyc;
    logic [3:0] eq;
    logic [3:0] er;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.dividend = 4'd0;
    bus_if.divisor  = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", bus_if.quotient, 4'd0);
    check("rst_remainder", bus_if.remainder, 4'd0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_dbz", bus_if.div_by_zero, 1'b0);
    rst_n = 1'b1;

    // Basic divides
    run_op("div_13_4", 4'd13, 4'd4, 5, 4'd3, 4'd1, 1'b0);
    run_op("div_15_1", 4'd15, 4'd1, 5, 4'd15, 4'd0, 1'b0);
    run_op("div_3_9", 4'd3, 4'd9, 5, 4'd0, 4'd3, 1'b0);

    // Divide by zero, then a valid divide clears the flag
    run_op("div_7_0", 4'd7, 4'd0, 1, 4'hF, 4'd7, 1'b1);
    run_op("div_after_zero", 4'd9, 4'd3, 5, 4'd3, 4'd0, 1'b0);

    // Start held through RUN and DONE with different operands
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.dividend = 4'd13;
    bus_if.divisor  = 4'd4;
    @(posedge clk);
    #1;
    bus_if.dividend = 4'd15;
    bus_if.divisor  = 4'd1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus_if.done || cyc > 20) break;
    end
    check("held_first_latency", cyc, 5);
    check("held_first_quotient", bus_if.quotient, 4'd3);
    check("held_first_remainder", bus_if.remainder, 4'd1);
    $display("[TB] held_first: 13 / 4 -> q=%0d r=%0d lat=%0d", bus_if.quotient, bus_if.remainder, cyc);
    @(negedge clk);
    check("held_idle_busy", bus_if.busy, 1'b0);
    check("held_idle_done", bus_if.done, 1'b0);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus_if.done || cyc > 20) break;
      check("held_second_hold_q", bus_if.quotient, 4'd3);
    end
    check("held_second_latency", cyc, 5);
    check("held_second_quotient", bus_if.quotient, 4'd15);
    check("held_second_remainder", bus_if.remainder, 4'd0);
    $display("[TB] held_second: 15 / 1 -> q=%0d r=%0d lat=%0d", bus_if.quotient, bus_if.remainder, cyc);
    @(negedge clk);

    // Reset during the second RUN cycle aborts the divide
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.dividend = 4'd13;
    bus_if.divisor  = 4'd4;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.start    = 1'b1;
    bus_if.dividend = 4'd5;
    bus_if.divisor  = 4'd1;
    @(negedge clk);
    rst_n        = 1'b1;
    bus_if.start = 1'b0;
    check("abort_quotient", bus_if.quotient, 4'd0);
    check("abort_remainder", bus_if.remainder, 4'd0);
    check("abort_busy", bus_if.busy, 1'b0);
    check("abort_done", bus_if.done, 1'b0);
    check("abort_dbz", bus_if.div_by_zero, 1'b0);
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.done) cyc++;
    end
    check("abort_no_done", cyc, 0);
    $display("[TB] abort: reset in RUN, done pulses seen=%0d", cyc);
    run_op("div_9_2", 4'd9, 4'd2, 5, 4'd4, 4'd1, 1'b0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 4'hF;
          er = 4'(a);
          run_op("sweep_zero", 4'(a), 4'(b), 1, eq, er, 1'b1);
        end else begin
          eq = 4'(a / b);
          er = 4'(a % b);
          run_op("sweep", 4'(a), 4'(b), 5, eq, er, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
